// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: shared FSM states, error-check constants and latency bounds
package mem_access_ctrl_pkg;
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_ISSUE, S_RD_WAIT, S_RESP} state_e;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  localparam logic [1:0] ALIGN_MASK = 2'b11;
  function automatic logic addr_err(input logic [31:0] a, input logic [31:0] words);
    return (|(a[1:0] & ALIGN_MASK)) || ({2'b00, a[31:2]} >= words);
  endfunction
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: CPU request/response and memory-side signals of mem_access_ctrl
interface mem_access_ctrl_if;
  logic        i_ReqValid;
  logic        i_ReqWrite;
  logic [31:0] i_ReqAddr;
  logic [31:0] i_ReqWData;
  logic        o_ReqReady;
  logic        o_RspValid;
  logic        i_RspReady;
  logic [31:0] o_RspRData;
  logic        o_RspErr;
  logic        o_WEnable;
  logic [31:0] o_WAddr;
  logic [31:0] o_WData;
  logic        o_REnable;
  logic [31:0] o_RAddr;
  logic [31:0] i_RData;
  logic        i_MemBusy;
  modport slave (
    input  i_ReqValid, i_ReqWrite, i_ReqAddr, i_ReqWData, i_RspReady, i_RData, i_MemBusy,
    output o_ReqReady, o_RspValid, o_RspRData, o_RspErr, o_WEnable, o_WAddr, o_WData,
           o_REnable, o_RAddr
  );
  modport master (
    output i_ReqValid, i_ReqWrite, i_ReqAddr, i_ReqWData, i_RspReady, i_RData, i_MemBusy,
    input  o_ReqReady, o_RspValid, o_RspRData, o_RspErr, o_WEnable, o_WAddr, o_WData,
           o_REnable, o_RAddr
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding CPU-to-memory access controller with range/alignment checks
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int MEM_WORDS    = 4096
) (
  input logic i_Clk,
  input logic i_Rst,
  mem_access_ctrl_if.slave bus
);
  localparam int CW = $clog2(READ_LATENCY + 1);
  if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX) begin : g_bad_lat
    $error("READ_LATENCY out of range");
  end
  if (MEM_WORDS < 1 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_words
    $error("MEM_WORDS must be a power of two");
  end
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic write_q, write_d, err_q, err_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic ready, issue, resp;
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_INIT:  state_d = bus.i_MemBusy ? S_INIT : S_IDLE;
      S_IDLE: if (ready && bus.i_ReqValid) begin
        write_d = bus.i_ReqWrite;
        addr_d  = bus.i_ReqAddr[31:2];
        wdata_d = bus.i_ReqWData;
        rdata_d = '0;
        err_d   = addr_err(bus.i_ReqAddr, 32'(MEM_WORDS));
        state_d = err_d ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d   = CW'(READ_LATENCY);
        state_d = write_q ? S_RESP : S_RD_WAIT;
      end
      S_RD_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          rdata_d = bus.i_RData;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = bus.i_RspReady ? S_IDLE : S_RESP;
      default: state_d = S_INIT;
    endcase
  end
  assign ready = (state_q == S_IDLE) && !bus.i_MemBusy;
  assign issue = (state_q == S_ISSUE);
  assign resp  = (state_q == S_RESP);
  // Address/data buses stay zero unless their strobe is active
  assign bus.o_ReqReady = ready;
  assign bus.o_RspValid = resp;
  assign bus.o_RspErr   = resp && err_q;
  assign bus.o_RspRData = (resp && !err_q && !write_q) ? rdata_q : '0;
  assign bus.o_WEnable  = issue && write_q;
  assign bus.o_REnable  = issue && !write_q;
  assign bus.o_WAddr    = bus.o_WEnable ? {2'b00, addr_q} : '0;
  assign bus.o_WData    = bus.o_WEnable ? wdata_q : '0;
  assign bus.o_RAddr    = bus.o_REnable ? {2'b00, addr_q} : '0;
endmodule
